data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data port. Serves loads on the read address and commits stores sized by the 2-bit write code.
- Contains a word-organised data RAM plus a small MMIO window with a free-running timer, compare/IRQ logic, an LED register and a sticky status register.
- Sits beside the core at top level. D_IN_ADDR drives RD_ADDR, D_OUT_ADDR drives WR_ADDR, D_OUT drives WR_DATA, WR drives WR, and RD_DATA drives the core's D_IN.

Parameters:
- DEPTH, 1024: RAM size in 32-bit words; must be a power of two.
- ADDR_W, 10: log2(DEPTH).
- MMIO_BASE, 32'hFFFF_FF00: base address of the 16-byte MMIO window.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- RD_ADDR  in  32  load byte address
- RD_DATA  out  32  load data; addressed byte in bits [7:0]
- WR_ADDR  in  32  store byte address
- WR_DATA  out->in  32  store data; LSB-aligned (byte in [7:0], half in [15:0])
- WR  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- TIMER_IRQ  out  1  timer interrupt pending, level
- LEDS  out  8  LED register bits [7:0]
- ERR  out  1  OR of the sticky status error bits

Behaviour:
- Reset (RST high at posedge):
  - MTIME=0, MTIMECMP=32'hFFFF_FFFF, LED=0, STATUS=0.
  - Outputs: TIMER_IRQ=0, LEDS=0, ERR=0.
  - RAM contents are not cleared.
  - A store presented in the same cycle as RST is dropped.
- Address decode:
  - RAM region: addr < DEPTH*4; word index addr[ADDR_W+1:2].
  - MMIO region: addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- Reads (combinational, zero latency; required by the single-cycle core):
  - RAM: RD_DATA = word >> (8*RD_ADDR[1:0]), zero-filled above.
  - MMIO word reads at offsets:
    - +0x0 MTIME
    - +0x4 MTIMECMP
    - +0x8 {24'b0, LED}
    - +0xC {29'b0, BUS_ERR, IRQ, MISALIGN}
  - Unmapped reads return 0.
  - Read and write to the same address in one cycle: RD_DATA shows the old contents; new contents are visible from the next cycle.
- Writes (commit at posedge when WR != 00):
  - Byte: lane WR_ADDR[1:0] takes WR_DATA[7:0]; other lanes unchanged.
  - Half: requires WR_ADDR[0]==0. Lanes {1,0} or {3,2} take WR_DATA[15:0].
  - Word: requires WR_ADDR[1:0]==0.
  - A misaligned store is dropped and sets MISALIGN.
  - A store to an unmapped address is dropped and sets BUS_ERR.
  - MMIO accepts word stores only. A byte/half store to MMIO is dropped and sets BUS_ERR. Writes to MTIME are ignored (read-only).
  - MTIMECMP write: loads the value and clears IRQ.
  - LED write: loads WR_DATA[7:0].
  - STATUS write: write-1-to-clear on bits [2:0].
- Timer:
  - MTIME increments by 1 every non-reset cycle and wraps 32'hFFFF_FFFF -> 0.
  - IRQ is set at the posedge where the pre-increment MTIME == MTIMECMP, and stays set until cleared.
  - If set and clear land in the same cycle (W1C or MTIMECMP write), set wins.
- ERR = MISALIGN | BUS_ERR. A new error in the same cycle as a W1C clear of that bit: set wins.

Decomposition:
- Shared package (data_mem_pkg):
  - WR encodings: WR_NONE, WR_BYTE, WR_HALF, WR_WORD.
  - MMIO offsets: OFF_MTIME, OFF_MTIMECMP, OFF_LED, OFF_STATUS.
  - STATUS bit indices: ST_MISALIGN=0, ST_IRQ=1, ST_BUSERR=2.
- One sub-module: mmio_timer, holding MTIME, MTIMECMP, IRQ set/clear and wrap.
- RAM array, lane-enable generation, decode and the remaining registers stay in the top level.

Test Plan:
- Reset, then read STATUS, MTIMECMP and LEDS -> 0, 32'hFFFF_FFFF, 8'h00.
- Word store 32'hDEAD_BEEF @0x10, then byte store 8'h5A @0x11:
  - read @0x10 -> 32'hDEAD_5AEF
  - read @0x13 -> 32'h0000_00DE
- Half store 16'h1234 @0x21:
  - RAM @0x20 unchanged
  - MISALIGN=1, ERR=1
  - STATUS W1C 32'h1 -> ERR=0
- MTIMECMP=5 written in cycle 0:
  - IRQ rises at the edge where MTIME==5
  - W1C of bit1 in the same cycle as a new match -> IRQ stays 1
- Byte store to 0xFFFF_FF08 -> LEDS unchanged, BUS_ERR=1. Word store 32'hA5 to 0xFFFF_FF08 -> LEDS=8'hA5.
- Same-cycle read and word write @0x40 (old 0, new 32'h1): RD_DATA=0 that cycle, 32'h1 next cycle. RST asserted mid-store -> store dropped, MTIME=0 next cycle.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and helpers for the data memory responder
package data_mem_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_BYTE = 2'b01,
        WR_HALF = 2'b10,
        WR_WORD = 2'b11
    } wr_size_e;

    localparam logic [3:0] OFF_MTIME    = 4'h0;
    localparam logic [3:0] OFF_MTIMECMP = 4'h4;
    localparam logic [3:0] OFF_LED      = 4'h8;
    localparam logic [3:0] OFF_STATUS   = 4'hC;

    localparam int ST_MISALIGN = 0;
    localparam int ST_IRQ      = 1;
    localparam int ST_BUSERR   = 2;

    function automatic logic [3:0] lane_mask(input wr_size_e size, input logic [1:0] lo);
        case (size)
            WR_BYTE: return 4'b0001 << lo;
            WR_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            WR_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic store_aligned(input wr_size_e size, input logic [1:0] lo);
        case (size)
            WR_HALF: return ~lo[0];
            WR_WORD: return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - free-running MTIME, MTIMECMP compare and sticky IRQ
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        irq_clr,
    output logic [31:0] mtime,
    output logic [31:0] mtimecmp,
    output logic        irq
);

    logic hit;
    assign hit = (mtime == mtimecmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= 32'd0;
            mtimecmp <= 32'hFFFF_FFFF;
            irq      <= 1'b0;
        end else begin
            mtime <= mtime + 32'd1;
            if (cmp_we) begin
                mtimecmp <= cmp_wdata;
            end
            // A match in the clearing cycle must not be lost, so set dominates.
            irq <= hit | (irq & ~irq_clr);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - core data-port responder: word RAM plus timer/LED/status MMIO
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] RD_ADDR,
    output logic [31:0] RD_DATA,
    input  logic [31:0] WR_ADDR,
    input  logic [31:0] WR_DATA,
    input  logic [1:0]  WR,
    output logic        TIMER_IRQ,
    output logic [7:0]  LEDS,
    output logic        ERR
);

    logic [31:0] mem [DEPTH];
    logic [7:0]  led_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic        irq;

    logic rd_in_ram, rd_in_mmio, wr_in_ram, wr_in_mmio;
    assign rd_in_ram  = (RD_ADDR[31:ADDR_W+2] == '0);
    assign rd_in_mmio = (RD_ADDR[31:4] == MMIO_BASE[31:4]);
    assign wr_in_ram  = (WR_ADDR[31:ADDR_W+2] == '0);
    assign wr_in_mmio = (WR_ADDR[31:4] == MMIO_BASE[31:4]);

    logic [31:0] ram_word;
    logic [31:0] status_word;
    logic [31:0] mmio_word;
    assign ram_word = mem[RD_ADDR[ADDR_W+1:2]];

    always_comb begin
        status_word              = '0;
        status_word[ST_MISALIGN] = misalign_q;
        status_word[ST_IRQ]      = irq;
        status_word[ST_BUSERR]   = bus_err_q;

        mmio_word = '0;
        case ({RD_ADDR[3:2], 2'b00})
            OFF_MTIME:    mmio_word = mtime;
            OFF_MTIMECMP: mmio_word = mtimecmp;
            OFF_LED:      mmio_word = {24'd0, led_q};
            OFF_STATUS:   mmio_word = status_word;
            default:      mmio_word = '0;
        endcase

        RD_DATA = '0;
        if (rd_in_ram) begin
            RD_DATA = ram_word >> {RD_ADDR[1:0], 3'b000};
        end else if (rd_in_mmio) begin
            RD_DATA = mmio_word;
        end
    end

    wr_size_e    wr_size;
    logic        wr_active, wr_aligned, is_word;
    logic        ram_we, mmio_we, set_misalign, set_bus_err;
    logic [3:0]  wr_off;
    logic [3:0]  wr_lanes;
    logic [31:0] wr_word;

    assign wr_size    = wr_size_e'(WR);
    assign wr_active  = (wr_size != WR_NONE);
    assign is_word    = (wr_size == WR_WORD);
    assign wr_aligned = store_aligned(wr_size, WR_ADDR[1:0]);
    assign wr_off     = {WR_ADDR[3:2], 2'b00};
    assign wr_lanes   = lane_mask(wr_size, WR_ADDR[1:0]);

    // RAM has no reset branch, so a store coinciding with reset is gated here.
    assign ram_we       = wr_active & wr_in_ram & wr_aligned & ~RST;
    assign mmio_we      = wr_active & wr_in_mmio & is_word & wr_aligned;
    assign set_bus_err  = wr_active & ((~wr_in_ram & ~wr_in_mmio) | (wr_in_mmio & ~is_word));
    assign set_misalign = wr_active & ~wr_aligned & (wr_in_ram | (wr_in_mmio & is_word));

    always_comb begin
        case (wr_size)
            WR_BYTE: wr_word = {4{WR_DATA[7:0]}};
            WR_HALF: wr_word = {2{WR_DATA[15:0]}};
            default: wr_word = WR_DATA;
        endcase
    end

    logic       cmp_we, led_we;
    logic [2:0] w1c_mask;
    logic       irq_clr;
    assign cmp_we   = mmio_we & (wr_off == OFF_MTIMECMP);
    assign led_we   = mmio_we & (wr_off == OFF_LED);
    assign w1c_mask = (mmio_we & (wr_off == OFF_STATUS)) ? WR_DATA[2:0] : 3'b000;
    assign irq_clr  = cmp_we | w1c_mask[ST_IRQ];

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lanes[i]) begin
                    mem[WR_ADDR[ADDR_W+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q      <= 8'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if (led_we) begin
                led_q <= WR_DATA[7:0];
            end
            misalign_q <= set_misalign | (misalign_q & ~w1c_mask[ST_MISALIGN]);
            bus_err_q  <= set_bus_err  | (bus_err_q  & ~w1c_mask[ST_BUSERR]);
        end
    end

    mmio_timer u_timer (
        .clk       (CLK),
        .rst       (RST),
        .cmp_we    (cmp_we),
        .cmp_wdata (WR_DATA),
        .irq_clr   (irq_clr),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .irq       (irq)
    );

    assign TIMER_IRQ = irq;
    assign LEDS      = led_q;
    assign ERR       = misalign_q | bus_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MMIO  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = 32'hFFFF_FF0C;
    logic [31:0] rd_data;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [1:0]  wr = 2'b00;
    logic        timer_irq;
    logic [7:0]  leds;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .MMIO_BASE(MMIO)) dut (
        .CLK       (clk),
        .RST       (rst),
        .RD_ADDR   (rd_addr),
        .RD_DATA   (rd_data),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .WR        (wr),
        .TIMER_IRQ (timer_irq),
        .LEDS      (leds),
        .ERR       (err)
    );

    // Byte-addressed little-endian picture of the memory map.
    logic [7:0]  m_ram [DEPTH*4];
    logic [31:0] m_mtime = 32'd0;
    logic [31:0] m_cmp = 32'hFFFF_FFFF;
    logic [7:0]  m_led = 8'd0;
    logic        m_mis = 1'b0;
    logic        m_bus = 1'b0;
    logic        m_irq = 1'b0;
    bit          m_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned ua;
        int unsigned base;
        logic [31:0] w;
        ua = a;
        if (ua < DEPTH*4) begin
            base = ua & ~32'd3;
            w = {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
            return w >> (8 * (ua % 4));
        end
        if ((ua >> 4) == (MMIO >> 4)) begin
            case ((ua >> 2) & 3)
                0:       return m_mtime;
                1:       return m_cmp;
                2:       return {24'd0, m_led};
                default: return {29'd0, m_bus, m_irq, m_mis};
            endcase
        end
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mtime = 32'd0;
            m_cmp   = 32'hFFFF_FFFF;
            m_led   = 8'd0;
            m_mis   = 1'b0;
            m_bus   = 1'b0;
            m_irq   = 1'b0;
            m_ready = 1'b1;
        end else begin
            int unsigned a;
            int unsigned n;
            bit hit, set_mis, set_bus, clr_irq;
            logic [2:0] w1c;
            a = wr_addr;
            hit = (m_mtime == m_cmp);
            set_mis = 1'b0;
            set_bus = 1'b0;
            clr_irq = 1'b0;
            w1c = 3'b000;
            if (wr != 2'b00) begin
                n = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
                if (a < DEPTH*4) begin
                    if (a % n != 0) set_mis = 1'b1;
                    else for (int k = 0; k < n; k++) m_ram[a+k] = wr_data[8*k +: 8];
                end else if ((a >> 4) == (MMIO >> 4)) begin
                    if (n != 4) set_bus = 1'b1;
                    else if (a % 4 != 0) set_mis = 1'b1;
                    else begin
                        case ((a >> 2) & 3)
                            1: begin m_cmp = wr_data; clr_irq = 1'b1; end
                            2: m_led = wr_data[7:0];
                            3: w1c = wr_data[2:0];
                            default: ;
                        endcase
                    end
                end else begin
                    set_bus = 1'b1;
                end
            end
            if (w1c[1]) clr_irq = 1'b1;
            m_mis   = set_mis | (m_mis & !w1c[0]);
            m_bus   = set_bus | (m_bus & !w1c[2]);
            m_irq   = hit | (m_irq & !clr_irq);
            m_mtime = m_mtime + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("rd_data", rd_data, model_read(rd_addr));
            check("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
            check("leds", {24'd0, leds}, {24'd0, m_led});
            check("err", {31'd0, err}, {31'd0, m_mis | m_bus});
        end
    end

    task automatic drive(input logic r, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] sz);
        @(posedge clk);
        #1;
        rst     = r;
        rd_addr = ra;
        wr_addr = wa;
        wr_data = wd;
        wr      = sz;
    endtask

    function automatic logic [31:0] pick_addr(input bit for_write);
        int unsigned sel;
        int unsigned w;
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            w = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 31);
            return w * 4 + $urandom_range(0, 3);
        end
        if (sel < 8) return MMIO + 4 * $urandom_range(0, 3);
        if (sel == 8) return 32'h0000_1000 + $urandom_range(0, 3);
        return for_write ? (32'h0010_0000 | ($urandom() & 32'h000F_FFFC))
                         : (32'h0020_0000 | ($urandom() & 32'h000F_FFFF));
    endfunction

    initial begin
        drive(1, MMIO + 12, 0, 0, 0);
        drive(1, MMIO + 12, 0, 0, 0);
        drive(0, MMIO + 12, 0, 0, 0);
        @(negedge clk);
        check("reset_status", rd_data, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_irq", {31'd0, timer_irq}, 32'd0);
        drive(0, MMIO + 4, 0, 0, 0);
        @(negedge clk);
        check("reset_mtimecmp", rd_data, 32'hFFFF_FFFF);
        check("reset_leds", {24'd0, leds}, 32'd0);

        for (int w = 0; w < 32; w++) drive(0, MMIO, 4 * w, 0, 2'b11);
        drive(0, MMIO, (DEPTH - 1) * 4, 0, 2'b11);

        drive(0, MMIO, 32'h10, 32'hDEAD_BEEF, 2'b11);
        drive(0, MMIO, 32'h11, 32'h0000_005A, 2'b01);
        drive(0, 32'h10, 0, 0, 0);
        @(negedge clk);
        check("byte_merge", rd_data, 32'hDEAD_5AEF);
        drive(0, 32'h13, 0, 0, 0);
        @(negedge clk);
        check("byte_shift_read", rd_data, 32'h0000_00DE);

        drive(0, MMIO + 12, 32'h21, 32'h0000_1234, 2'b10);
        drive(0, 32'h20, 0, 0, 0);
        @(negedge clk);
        check("misaligned_half_dropped", rd_data, 32'd0);
        check("misalign_err", {31'd0, err}, 32'd1);
        drive(0, MMIO + 12, MMIO + 12, 32'h1, 2'b11);
        @(negedge clk);
        check("status_misalign", rd_data, 32'h1);
        drive(0, MMIO + 12, 0, 0, 0);
        @(negedge clk);
        check("w1c_clears_err", {31'd0, err}, 32'd0);

        drive(0, MMIO + 8, MMIO + 8, 32'hA5, 2'b01);
        drive(0, MMIO + 12, 0, 0, 0);
        @(negedge clk);
        check("mmio_byte_leds", {24'd0, leds}, 32'd0);
        check("mmio_byte_buserr", rd_data, 32'h4);
        drive(0, MMIO + 8, MMIO + 8, 32'hA5, 2'b11);
        drive(0, MMIO + 8, 0, 0, 0);
        @(negedge clk);
        check("led_word_store", {24'd0, leds}, 32'hA5);

        drive(0, 32'h40, 32'h40, 32'h1, 2'b11);
        @(negedge clk);
        check("rw_same_cycle_old", rd_data, 32'd0);
        drive(0, 32'h40, 0, 0, 0);
        @(negedge clk);
        check("rw_next_cycle_new", rd_data, 32'h1);

        drive(1, 32'h44, 32'h44, 32'h77, 2'b11);
        drive(0, MMIO, MMIO + 4, 32'd5, 2'b11);
        @(negedge clk);
        check("mtime_after_reset", rd_data, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, MMIO, 0, 0, 0);
            @(negedge clk);
            check("mtime_count", rd_data, k);
            check("irq_before_match", {31'd0, timer_irq}, 32'd0);
        end
        drive(0, MMIO + 12, 0, 0, 0);
        @(negedge clk);
        check("irq_on_match", {31'd0, timer_irq}, 32'd1);
        check("status_irq", rd_data, 32'h2);
        drive(0, MMIO, MMIO + 4, 32'd9, 2'b11);
        @(negedge clk);
        check("mtime_7", rd_data, 32'd7);
        drive(0, MMIO, 0, 0, 0);
        @(negedge clk);
        check("cmp_write_clears_irq", {31'd0, timer_irq}, 32'd0);
        drive(0, MMIO, MMIO + 12, 32'h2, 2'b11);
        @(negedge clk);
        check("mtime_9", rd_data, 32'd9);
        drive(0, MMIO, MMIO + 12, 32'h2, 2'b11);
        @(negedge clk);
        check("irq_set_beats_w1c", {31'd0, timer_irq}, 32'd1);
        drive(0, 32'h44, 0, 0, 0);
        @(negedge clk);
        check("irq_w1c_clears", {31'd0, timer_irq}, 32'd0);
        check("store_in_reset_dropped", rd_data, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, wa, wd;
            logic [1:0]  sz;
            logic        r;
            ra = pick_addr(1'b0);
            wa = pick_addr(1'b1);
            sz = 2'($urandom_range(0, 3));
            wd = $urandom();
            if (wa == MMIO + 4) wd = m_mtime + $urandom_range(1, 30);
            r = ($urandom_range(0, 199) == 0);
            drive(r, ra, wa, wd, sz);
        end
        drive(0, MMIO, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
